calculator: RTL and testbench

- RPN (stack-based) 16-bit signed integer calculator.
- Consumes one 20-bit command word per clock: upper 4 bits are a one-hot command, lower 16 bits are an operand or operation code.
- A transaction runs start → enter/arithOp* → done. At done, the block reports the result on the stack, or an error.
- Sits behind a word-stream interface. There is no backpressure: every clock carries one word.

---
 rtl/calc_pkg.sv | 37 +++
 rtl/calculator_if.sv | 24 ++
 rtl/calc_stack.sv | 73 +++++++
 rtl/calculator.sv | 188 ++++++++++++++++++
 tb/tb_calculator.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the RPN calculator: command/op encodings, FSM states,
// stack operation codes and default geometry.
package calc_pkg;

  localparam int CALC_WIDTH = 16;
  localparam int CALC_DEPTH = 8;

  localparam logic [3:0] CMD_START = 4'h1;
  localparam logic [3:0] CMD_ENTER = 4'h2;
  localparam logic [3:0] CMD_ARITH = 4'h4;
  localparam logic [3:0] CMD_DONE  = 4'h8;

  localparam logic [15:0] OP_ADD  = 16'h0001;
  localparam logic [15:0] OP_SUB  = 16'h0002;
  localparam logic [15:0] OP_AND  = 16'h0004;
  localparam logic [15:0] OP_SWAP = 16'h0008;
  localparam logic [15:0] OP_NEG  = 16'h0010;
  localparam logic [15:0] OP_POP  = 16'h0020;
  localparam logic [15:0] OP_MUL  = 16'h0040;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    STK_NONE = 3'd0,
    STK_LOAD = 3'd1,
    STK_PUSH = 3'd2,
    STK_POP  = 3'd3,
    STK_REP1 = 3'd4,
    STK_REP2 = 3'd5,
    STK_SWAP = 3'd6
  } stk_op_e;

endpackage

// File: rtl/calculator_if.sv
// Word-stream interface of the calculator: one command word in per clock,
// registered result and status flags out.
interface calculator_if #(parameter int WIDTH = 16);
  logic [WIDTH+3:0] data;
  logic [WIDTH-1:0] result;
  logic             stackOverflow;
  logic             unexpectedDone;
  logic             dataOverflow;
  logic             protocolError;
  logic             correct;
  logic             finished;

  modport master (
    output data,
    input  result, stackOverflow, unexpectedDone, dataOverflow,
    input  protocolError, correct, finished
  );

  modport slave (
    input  data,
    output result, stackOverflow, unexpectedDone, dataOverflow,
    output protocolError, correct, finished
  );
endinterface

// File: rtl/calc_stack.sv
// Operand stack: DEPTH x WIDTH register file with a depth counter. Entry 0 is the
// bottom; one load/push/pop/replace/swap operation per cycle.
module calc_stack
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_WIDTH,
  parameter int DEPTH = CALC_DEPTH,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int IW = $clog2(DEPTH)
) (
  input  logic             ck,
  input  logic             rst_l,
  input  stk_op_e          op,
  input  logic [WIDTH-1:0] val,
  output logic [WIDTH-1:0] top,
  output logic [WIDTH-1:0] second,
  output logic [CW-1:0]    depth,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [WIDTH-1:0] stack_d [DEPTH];
  logic [CW-1:0]    depth_q, depth_d;
  logic [IW-1:0]    top_idx_s, sec_idx_s;

  assign top_idx_s = IW'(depth_q - CW'(1));
  assign sec_idx_s = IW'(depth_q - CW'(2));
  assign top       = stack_q[top_idx_s];
  assign second    = stack_q[sec_idx_s];
  assign depth     = depth_q;
  assign full      = (depth_q == CW'(DEPTH));
  assign empty     = (depth_q == CW'(0));

  // next stack contents for the requested operation
  always_comb begin
    stack_d = stack_q;
    depth_d = depth_q;
    case (op)
      STK_LOAD: begin
        stack_d[0] = val;
        depth_d    = CW'(1);
      end
      STK_PUSH: begin
        stack_d[IW'(depth_q)] = val;
        depth_d               = depth_q + CW'(1);
      end
      STK_POP:  depth_d = depth_q - CW'(1);
      STK_REP1: stack_d[top_idx_s] = val;
      STK_REP2: begin
        stack_d[sec_idx_s] = val;
        depth_d            = depth_q - CW'(1);
      end
      STK_SWAP: begin
        stack_d[top_idx_s] = stack_q[sec_idx_s];
        stack_d[sec_idx_s] = stack_q[top_idx_s];
      end
      default: depth_d = depth_q;
    endcase
  end

  // stack state registers
  always_ff @(posedge ck or negedge rst_l) begin
    if (!rst_l) begin
      depth_q <= CW'(0);
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= WIDTH'(0);
    end else begin
      depth_q <= depth_d;
      stack_q <= stack_d;
    end
  end

endmodule

// File: rtl/calculator.sv
// RPN 16-bit signed calculator: START/ENTER/ARITH/DONE command stream with registered
// result and error flags. Define CALC_MUL_EN to make the MUL op legal.
module calculator
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_WIDTH,
  parameter int DEPTH = CALC_DEPTH,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic         ck,
  input  logic         rst_l,
  calculator_if.slave  bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             stack_ovf_q, stack_ovf_d, unexp_done_q, unexp_done_d;
  logic             data_ovf_q, data_ovf_d, proto_err_q, proto_err_d;
  logic             correct_q, correct_d, finished_q, finished_d;

  logic [3:0]       cmd_s;
  logic [WIDTH-1:0] val_s, a_s, b_s, op_val_s, stk_val_s;
  logic [WIDTH:0]   sum_s, diff_s;
  logic [CW-1:0]    depth_s;
  logic             full_s, empty_s, op_legal_s, need_two_s, op_ovf_s, depth_ok_s;
  stk_op_e          op_stk_s, stk_op_s;

  assign cmd_s  = bus.data[WIDTH+3:WIDTH];
  assign val_s  = bus.data[WIDTH-1:0];
  assign sum_s  = {a_s[WIDTH-1], a_s} + {b_s[WIDTH-1], b_s};
  assign diff_s = {a_s[WIDTH-1], a_s} - {b_s[WIDTH-1], b_s};

`ifdef CALC_MUL_EN
  logic signed [2*WIDTH-1:0] prod_s;
  assign prod_s = $signed(a_s) * $signed(b_s);
`endif

  calc_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_stack (
    .ck(ck), .rst_l(rst_l), .op(stk_op_s), .val(stk_val_s),
    .top(b_s), .second(a_s), .depth(depth_s), .full(full_s), .empty(empty_s)
  );

  // decode the ARITH op: legality, operand count, overflow, stack effect
  always_comb begin
    op_legal_s = 1'b1;
    need_two_s = 1'b1;
    op_ovf_s   = 1'b0;
    op_stk_s   = STK_REP2;
    op_val_s   = sum_s[WIDTH-1:0];
    case (val_s)
      OP_ADD: op_ovf_s = (sum_s[WIDTH] != sum_s[WIDTH-1]);
      OP_SUB: begin
        op_val_s = diff_s[WIDTH-1:0];
        op_ovf_s = (diff_s[WIDTH] != diff_s[WIDTH-1]);
      end
      OP_AND:  op_val_s = a_s & b_s;
      OP_SWAP: op_stk_s = STK_SWAP;
      OP_NEG: begin
        need_two_s = 1'b0;
        op_stk_s   = STK_REP1;
        op_val_s   = WIDTH'(0) - b_s;
        op_ovf_s   = (b_s == {1'b1, {(WIDTH-1){1'b0}}});
      end
      OP_POP: op_stk_s = STK_POP;
`ifdef CALC_MUL_EN
      OP_MUL: begin
        op_val_s = prod_s[WIDTH-1:0];
        op_ovf_s = !((&prod_s[2*WIDTH-1:WIDTH-1]) || !(|prod_s[2*WIDTH-1:WIDTH-1]));
      end
`endif
      default: op_legal_s = 1'b0;
    endcase
    if (need_two_s) depth_ok_s = (depth_s >= CW'(2));
    else            depth_ok_s = !empty_s;
  end

  // transaction FSM and output flag next-state
  always_comb begin
    state_d      = state_q;
    result_d     = result_q;
    stack_ovf_d  = stack_ovf_q;
    unexp_done_d = unexp_done_q;
    data_ovf_d   = data_ovf_q;
    proto_err_d  = proto_err_q;
    correct_d    = correct_q;
    finished_d   = finished_q;
    stk_op_s     = STK_NONE;
    stk_val_s    = val_s;
    case (state_q)
      ST_IDLE: begin
        if (cmd_s == CMD_START) begin
          stk_op_s     = STK_LOAD;
          result_d     = WIDTH'(0);
          stack_ovf_d  = 1'b0;
          unexp_done_d = 1'b0;
          data_ovf_d   = 1'b0;
          proto_err_d  = 1'b0;
          correct_d    = 1'b0;
          finished_d   = 1'b0;
          state_d      = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        case (cmd_s)
          CMD_ENTER: begin
            if (full_s) begin
              stack_ovf_d = 1'b1;
              state_d     = ST_ERR;
            end else begin
              stk_op_s = STK_PUSH;
            end
          end
          CMD_ARITH: begin
            if (!op_legal_s || !depth_ok_s) begin
              proto_err_d = 1'b1;
              state_d     = ST_ERR;
            end else if (op_ovf_s) begin
              data_ovf_d = 1'b1;
              state_d    = ST_ERR;
            end else begin
              stk_op_s  = op_stk_s;
              stk_val_s = op_val_s;
            end
          end
          CMD_DONE: begin
            finished_d = 1'b1;
            state_d    = ST_IDLE;
            if (depth_s == CW'(1)) begin
              result_d  = b_s;
              correct_d = 1'b1;
            end else begin
              unexp_done_d = 1'b1;
              correct_d    = 1'b0;
            end
          end
          default: begin
            proto_err_d = 1'b1;
            state_d     = ST_ERR;
          end
        endcase
      end
      ST_ERR: begin
        if (cmd_s == CMD_DONE) begin
          finished_d = 1'b1;
          correct_d  = 1'b0;
          state_d    = ST_IDLE;
        end else begin
          state_d = ST_ERR;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state and output registers
  always_ff @(posedge ck or negedge rst_l) begin
    if (!rst_l) begin
      state_q      <= ST_IDLE;
      result_q     <= WIDTH'(0);
      stack_ovf_q  <= 1'b0;
      unexp_done_q <= 1'b0;
      data_ovf_q   <= 1'b0;
      proto_err_q  <= 1'b0;
      correct_q    <= 1'b0;
      finished_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      result_q     <= result_d;
      stack_ovf_q  <= stack_ovf_d;
      unexp_done_q <= unexp_done_d;
      data_ovf_q   <= data_ovf_d;
      proto_err_q  <= proto_err_d;
      correct_q    <= correct_d;
      finished_q   <= finished_d;
    end
  end

  assign bus.result         = result_q;
  assign bus.stackOverflow  = stack_ovf_q;
  assign bus.unexpectedDone = unexp_done_q;
  assign bus.dataOverflow   = data_ovf_q;
  assign bus.protocolError  = proto_err_q;
  assign bus.correct        = correct_q;
  assign bus.finished       = finished_q;

endmodule

// File: tb/tb_calculator.sv
// Directed self-checking bench for the RPN calculator; flag vectors are packed as
// {stackOverflow, unexpectedDone, dataOverflow, protocolError, correct, finished}.
module tb_calculator;
  import calc_pkg::*;

  localparam logic [5:0] F_NONE   = 6'b000000;
  localparam logic [5:0] F_OK     = 6'b000011;
  localparam logic [5:0] F_PE     = 6'b000100;
  localparam logic [5:0] F_PE_END = 6'b000101;
  localparam logic [5:0] F_UD     = 6'b010001;
  localparam logic [5:0] F_DO     = 6'b001000;
  localparam logic [5:0] F_DO_END = 6'b001001;
  localparam logic [5:0] F_SO     = 6'b100000;
  localparam logic [5:0] F_SO_END = 6'b100001;

  logic ck = 1'b0;
  logic rst_l;
  int   n_cmp = 0;
  int   n_err = 0;

  calculator_if bus ();
  calculator dut (.ck(ck), .rst_l(rst_l), .bus(bus));

  always #5 ck = ~ck;

  task automatic send(input logic [3:0] c, input logic [15:0] v);
    bus.data = {c, v};
    @(posedge ck);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [15:0] res, input logic [5:0] flg);
    check({tag, " result"}, bus.result, res);
    check({tag, " flags"},
          {10'd0, bus.stackOverflow, bus.unexpectedDone, bus.dataOverflow,
           bus.protocolError, bus.correct, bus.finished},
          {10'd0, flg});
  endtask

  // run a two-operand op and finish, checking the final outputs
  task automatic binop(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] op, input logic [15:0] res, input logic [5:0] flg);
    send(CMD_START, a);
    send(CMD_ENTER, b);
    send(CMD_ARITH, op);
    send(CMD_DONE, 16'h0000);
    check_out(tag, res, flg);
  endtask

  initial begin
    rst_l    = 1'b0;
    bus.data = 20'h0_0000;
    repeat (2) @(posedge ck);
    #1;
    check_out("reset", 16'h0000, F_NONE);
    rst_l = 1'b1;

    binop("add", 16'h0005, 16'h0006, OP_ADD, 16'h000B, F_OK);
    send(CMD_ENTER, 16'h0009);
    check_out("idle_ignore", 16'h000B, F_OK);
    binop("sub", 16'h0008, 16'h0006, OP_SUB, 16'h0002, F_OK);
    binop("and", 16'h0005, 16'h000F, OP_AND, 16'h0005, F_OK);
    binop("add_min_edge", 16'hFFFF, 16'h8001, OP_ADD, 16'h8000, F_OK);
    binop("sub_min_edge", 16'h0000, 16'h7FFF, OP_SUB, 16'h8001, F_OK);

    send(CMD_START, 16'h0001);
    check_out("start_clears", 16'h0000, F_NONE);
    send(CMD_ENTER, 16'h0002);
    send(CMD_ARITH, OP_SWAP);
    send(CMD_ARITH, OP_POP);
    send(CMD_DONE, 16'h0000);
    check_out("swap_pop", 16'h0002, F_OK);

    send(CMD_START, 16'h0005);
    send(CMD_ARITH, OP_NEG);
    send(CMD_DONE, 16'h0000);
    check_out("neg", 16'hFFFB, F_OK);

    // depth 3: 10 - (3 + 4)
    send(CMD_START, 16'h000A);
    send(CMD_ENTER, 16'h0003);
    send(CMD_ENTER, 16'h0004);
    send(CMD_ARITH, OP_ADD);
    send(CMD_ARITH, OP_SUB);
    send(CMD_DONE, 16'h0000);
    check_out("deep_chain", 16'h0003, F_OK);

    send(CMD_START, 16'h0001);
    send(CMD_ARITH, OP_ADD);
    check_out("pe_underflow", 16'h0000, F_PE);
    send(CMD_ENTER, 16'h0002);
    check_out("err_ignore", 16'h0000, F_PE);
    send(CMD_DONE, 16'h0000);
    check_out("pe_done", 16'h0000, F_PE_END);

    send(CMD_START, 16'h0001);
    send(CMD_ENTER, 16'h0002);
    send(CMD_START, 16'h0003);
    check_out("pe_start", 16'h0000, F_PE);
    send(CMD_DONE, 16'h0000);

    send(CMD_START, 16'h0001);
    send(4'h0, 16'h0000);
    check_out("pe_cmd0", 16'h0000, F_PE);
    send(CMD_DONE, 16'h0000);

    send(CMD_START, 16'h0001);
    send(CMD_ARITH, OP_POP);
    check_out("pe_pop1", 16'h0000, F_PE);
    send(CMD_DONE, 16'h0000);

    binop("pe_badop", 16'h0003, 16'h0004, 16'h0003, 16'h0000, F_PE_END);
`ifdef CALC_MUL_EN
    binop("mul", 16'h0003, 16'h0004, OP_MUL, 16'h000C, F_OK);
    binop("mul_ovf", 16'h0100, 16'h0100, OP_MUL, 16'h0000, F_DO_END);
`else
    binop("mul_off", 16'h0003, 16'h0004, OP_MUL, 16'h0000, F_PE_END);
`endif

    send(CMD_START, 16'h0001);
    send(CMD_ENTER, 16'h0002);
    send(CMD_DONE, 16'h0000);
    check_out("unexp_done", 16'h0000, F_UD);

    binop("ovf_8000p8000", 16'h8000, 16'h8000, OP_ADD, 16'h0000, F_DO_END);
    binop("ovf_7fffp7fff", 16'h7FFF, 16'h7FFF, OP_ADD, 16'h0000, F_DO_END);
    binop("ovf_8000m7fff", 16'h8000, 16'h7FFF, OP_SUB, 16'h0000, F_DO_END);
    binop("ovf_7fffm8000", 16'h7FFF, 16'h8000, OP_SUB, 16'h0000, F_DO_END);

    send(CMD_START, 16'h8000);
    send(CMD_ARITH, OP_NEG);
    check_out("ovf_neg", 16'h0000, F_DO);
    send(CMD_DONE, 16'h0000);

    send(CMD_START, 16'h0001);
    for (int v = 2; v <= 8; v++) send(CMD_ENTER, 16'(v));
    check_out("stack_full", 16'h0000, F_NONE);
    send(CMD_ENTER, 16'h0009);
    check_out("stack_ovf", 16'h0000, F_SO);
    send(CMD_ENTER, 16'h000A);
    send(CMD_DONE, 16'h0000);
    check_out("stack_ovf_done", 16'h0000, F_SO_END);
    send(CMD_START, 16'h0007);
    check_out("restart_clears", 16'h0000, F_NONE);
    send(CMD_DONE, 16'h0000);
    check_out("restart_done", 16'h0007, F_OK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
